// File: rtl/moore_seq_pkg.sv
// Shared types and helpers for the parametrised Moore sequence detector.
// The prefix-match function is the combinational core of the next-state logic.
package moore_seq_pkg;

    localparam int MAX_PATTERN_LEN = 16;
    localparam logic [3:0] DEFAULT_PATTERN = 4'b1101;

    // Wide enough for any supported PATTERN_LEN (state 0..16).
    typedef logic [$clog2(MAX_PATTERN_LEN+1)-1:0] state_t;

    // Longest k (<= len, <= max_k) such that the last k bits of {history, bit_in}
    // equal the first k bits of pattern. max_k stops stale history bits (after
    // reset, reload or a non-overlapping restart) from producing a false match.
    function automatic state_t prefix_match_len(
        input logic [MAX_PATTERN_LEN-2:0] history,
        input logic                       bit_in,
        input logic [MAX_PATTERN_LEN-1:0] pattern,
        input int                         len,
        input int                         max_k
    );
        logic [MAX_PATTERN_LEN-1:0] seq;
        logic [MAX_PATTERN_LEN-1:0] mask;
        logic [MAX_PATTERN_LEN-1:0] prefix;
        state_t                     best;
        best = '0;
        seq  = {history, bit_in};
        for (int k = 1; k <= MAX_PATTERN_LEN; k++) begin
            if (k <= len && k <= max_k) begin
                mask   = (MAX_PATTERN_LEN'(1) << k) - MAX_PATTERN_LEN'(1);
                prefix = (pattern >> (len - k)) & mask;
                if ((seq & mask) == prefix) begin
                    best = state_t'(k);
                end
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/moore_seq_det_cnt.sv
// Saturating match counter with synchronous clear (clear wins over increment).
// Only instantiated when MOORE_SEQ_CNT_EN is defined.
module moore_seq_det_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/moore_seq_det.sv
// Parametrised Moore serial sequence detector with runtime-loadable pattern.
// Optional saturating match counter enabled by the MOORE_SEQ_CNT_EN macro.
//
// state        | meaning
// 0            | no prefix of the pattern seen
// k (1..LEN-1) | last k accepted bits equal the first k pattern bits
// LEN          | MATCH, o = 1
module moore_seq_det
    import moore_seq_pkg::*;
#(
    parameter int                     PATTERN_LEN   = 4,
    parameter logic [PATTERN_LEN-1:0] RESET_PATTERN = PATTERN_LEN'(DEFAULT_PATTERN),
    parameter int                     CNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   i,
    input  logic                   i_valid,
    input  logic                   overlap,
    input  logic                   pat_load,
    input  logic [PATTERN_LEN-1:0] pat_in,
    output logic                   o
`ifdef MOORE_SEQ_CNT_EN
   ,output logic [CNT_W-1:0]       match_count,
    input  logic                   count_clr
`endif
);

    localparam state_t ST_MATCH = state_t'(PATTERN_LEN);

    if (PATTERN_LEN < 2 || PATTERN_LEN > MAX_PATTERN_LEN || CNT_W < 1) begin : g_bad_param
        $error("moore_seq_det: PATTERN_LEN must be 2..16 and CNT_W >= 1");
    end

    state_t                   state, state_next;
    logic [PATTERN_LEN-2:0]   history, history_next;
    logic [PATTERN_LEN-1:0]   pattern, pattern_next;
    logic [PATTERN_LEN-1:0]   hist_shift;
    logic                     o_next;
    int                       max_k;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= '0;
            history <= '0;
            pattern <= RESET_PATTERN;
            o       <= 1'b0;
        end else begin
            state   <= state_next;
            history <= history_next;
            pattern <= pattern_next;
            o       <= o_next;
        end
    end

    always_comb begin
        state_next   = state;
        history_next = history;
        pattern_next = pattern;
        hist_shift   = {history, i};
        // Non-overlapping restart after MATCH: only the new bit can count.
        if (!overlap && (state == ST_MATCH)) begin
            max_k = 1;
        end else begin
            max_k = int'(state) + 1;
        end
        if (pat_load) begin
            pattern_next = pat_in;
            state_next   = '0;
            history_next = '0;
        end else if (i_valid) begin
            state_next   = prefix_match_len((MAX_PATTERN_LEN-1)'(history), i,
                                            MAX_PATTERN_LEN'(pattern), PATTERN_LEN, max_k);
            history_next = hist_shift[PATTERN_LEN-2:0];
        end
        o_next = (state_next == ST_MATCH);
    end

`ifdef MOORE_SEQ_CNT_EN
    logic match_inc;
    assign match_inc = i_valid && !pat_load && (state_next == ST_MATCH);

    moore_seq_det_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (count_clr),
        .inc   (match_inc),
        .count (match_count)
    );
`endif

endmodule

// File: tb/tb_moore_seq_det.sv
// Directed self-checking bench for moore_seq_det (counter checks when
// MOORE_SEQ_CNT_EN is defined).
module tb_moore_seq_det;

    localparam int PL = 4;
    localparam int CW = 2;

    logic          tb_clk;
    logic          n_rst;
    logic          i;
    logic          i_valid;
    logic          overlap;
    logic          pat_load;
    logic [PL-1:0] pat_in;
    logic          o;
`ifdef MOORE_SEQ_CNT_EN
    logic [CW-1:0] match_count;
    logic          count_clr;
`endif

    int checks = 0;
    int errors = 0;

    moore_seq_det #(
        .PATTERN_LEN   (PL),
        .RESET_PATTERN (4'b1101),
        .CNT_W         (CW)
    ) dut (
        .clk         (tb_clk),
        .n_rst       (n_rst),
        .i           (i),
        .i_valid     (i_valid),
        .overlap     (overlap),
        .pat_load    (pat_load),
        .pat_in      (pat_in),
        .o           (o)
`ifdef MOORE_SEQ_CNT_EN
       ,.match_count (match_count),
        .count_clr   (count_clr)
`endif
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic chk_o(input string tag, input logic exp);
        checks++;
        assert (o === exp) else begin
            errors++;
            $error("FAIL %s o=%b expected=%b", tag, o, exp);
        end
    endtask

`ifdef MOORE_SEQ_CNT_EN
    task automatic chk_cnt(input string tag, input logic [CW-1:0] exp);
        checks++;
        assert (match_count === exp) else begin
            errors++;
            $error("FAIL %s match_count=%0d expected=%0d", tag, match_count, exp);
        end
    endtask
`endif

    // Called at a negedge: present one bit, let a posedge accept it, return at the next negedge.
    task automatic send_bit(input logic b);
        i       = b;
        i_valid = 1'b1;
        @(posedge tb_clk);
        @(negedge tb_clk);
        i_valid = 1'b0;
    endtask

    task automatic send_chk(input string tag, input logic b, input logic exp);
        send_bit(b);
        chk_o(tag, exp);
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        #2;
        n_rst = 1'b1;
        @(negedge tb_clk);
    endtask

    task automatic load_pat(input logic [PL-1:0] p);
        pat_in   = p;
        pat_load = 1'b1;
        @(posedge tb_clk);
        @(negedge tb_clk);
        pat_load = 1'b0;
    endtask

    initial begin
        n_rst    = 1'b1;
        i        = 1'b0;
        i_valid  = 1'b0;
        overlap  = 1'b0;
        pat_load = 1'b0;
        pat_in   = '0;
`ifdef MOORE_SEQ_CNT_EN
        count_clr = 1'b0;
`endif

        // 1: power-on reset
        #3 n_rst = 1'b0;
        #1 chk_o("rst_async", 1'b0);
        @(posedge tb_clk);
        @(negedge tb_clk);
        chk_o("rst_held", 1'b0);
        n_rst = 1'b1;
        #1 chk_o("rst_release", 1'b0);
`ifdef MOORE_SEQ_CNT_EN
        chk_cnt("rst_cnt", 2'd0);
`endif
        @(negedge tb_clk);

        // 2: default pattern 1101, non-overlapping
        overlap = 1'b0;
        send_chk("p1101_b1", 1'b1, 1'b0);
        send_chk("p1101_b2", 1'b1, 1'b0);
        send_chk("p1101_b3", 1'b0, 1'b0);
        send_chk("p1101_b4", 1'b1, 1'b1);

        // 3: 1101101 overlapping, then non-overlapping
        do_reset();
        overlap = 1'b1;
        send_chk("ov_b1", 1'b1, 1'b0);
        send_chk("ov_b2", 1'b1, 1'b0);
        send_chk("ov_b3", 1'b0, 1'b0);
        send_chk("ov_b4", 1'b1, 1'b1);
        send_chk("ov_b5", 1'b1, 1'b0);
        send_chk("ov_b6", 1'b0, 1'b0);
        send_chk("ov_b7", 1'b1, 1'b1);
`ifdef MOORE_SEQ_CNT_EN
        chk_cnt("ov_cnt", 2'd2);
`endif
        do_reset();
        overlap = 1'b0;
        send_chk("nov_b1", 1'b1, 1'b0);
        send_chk("nov_b2", 1'b1, 1'b0);
        send_chk("nov_b3", 1'b0, 1'b0);
        send_chk("nov_b4", 1'b1, 1'b1);
        send_chk("nov_b5", 1'b1, 1'b0);
        send_chk("nov_b6", 1'b0, 1'b0);
        send_chk("nov_b7", 1'b1, 1'b0);
`ifdef MOORE_SEQ_CNT_EN
        chk_cnt("nov_cnt", 2'd1);
`endif

        // 4: pattern 0000, overlapping then non-overlapping
        do_reset();
        load_pat(4'b0000);
        chk_o("load_o", 1'b0);
        overlap = 1'b1;
        send_chk("z_ov_b1", 1'b0, 1'b0);
        send_chk("z_ov_b2", 1'b0, 1'b0);
        send_chk("z_ov_b3", 1'b0, 1'b0);
        send_chk("z_ov_b4", 1'b0, 1'b1);
        send_chk("z_ov_b5", 1'b0, 1'b1);
        send_chk("z_ov_b6", 1'b0, 1'b1);
`ifdef MOORE_SEQ_CNT_EN
        chk_cnt("z_ov_cnt", 2'd3);
`endif
        load_pat(4'b0000);
        chk_o("reload_o", 1'b0);
        overlap = 1'b0;
        send_chk("z_nov_b1", 1'b0, 1'b0);
        send_chk("z_nov_b2", 1'b0, 1'b0);
        send_chk("z_nov_b3", 1'b0, 1'b0);
        send_chk("z_nov_b4", 1'b0, 1'b1);
        send_chk("z_nov_b5", 1'b0, 1'b0);
        send_chk("z_nov_b6", 1'b0, 1'b0);
`ifdef MOORE_SEQ_CNT_EN
        chk_cnt("load_keeps_cnt", 2'd3);

        // Saturation: clear, then six overlapping matches on 0000
        count_clr = 1'b1;
        @(posedge tb_clk);
        @(negedge tb_clk);
        count_clr = 1'b0;
        chk_cnt("clr_cnt", 2'd0);
        load_pat(4'b0000);
        overlap = 1'b1;
        for (int n = 0; n < 9; n++) send_bit(1'b0);
        chk_o("sat_o", 1'b1);
        chk_cnt("sat_cnt", 2'd3);

        // count_clr coincident with a MATCH->MATCH transition
        count_clr = 1'b1;
        send_bit(1'b0);
        count_clr = 1'b0;
        chk_cnt("clr_vs_match", 2'd0);
        send_bit(1'b0);
        chk_cnt("inc_after_clr", 2'd1);
`endif

        // 5: i_valid gap with toggling i
        do_reset();
        overlap = 1'b0;
        send_chk("gap_b1", 1'b1, 1'b0);
        send_chk("gap_b2", 1'b1, 1'b0);
        for (int n = 0; n < 3; n++) begin
            i = n[0];
            @(posedge tb_clk);
            @(negedge tb_clk);
            chk_o("gap_idle", 1'b0);
        end
        send_chk("gap_b3", 1'b0, 1'b0);
        send_chk("gap_b4", 1'b1, 1'b1);
        i = 1'b0;
        @(posedge tb_clk);
        @(negedge tb_clk);
        chk_o("match_hold1", 1'b1);
        i = 1'b1;
        @(posedge tb_clk);
        @(negedge tb_clk);
        chk_o("match_hold2", 1'b1);

        // 6: reset mid-stream loses the partial match
        do_reset();
        send_chk("mid_b1", 1'b1, 1'b0);
        send_chk("mid_b2", 1'b1, 1'b0);
        send_chk("mid_b3", 1'b0, 1'b0);
        n_rst = 1'b0;
        #1 chk_o("mid_rst_o", 1'b0);
        #1 n_rst = 1'b1;
        @(negedge tb_clk);
        send_chk("mid_after", 1'b1, 1'b0);

        // Reset restores 1101 after a 0000 load
        load_pat(4'b0000);
        send_chk("rp_b1", 1'b0, 1'b0);
        send_chk("rp_b2", 1'b0, 1'b0);
        send_chk("rp_b3", 1'b0, 1'b0);
        do_reset();
        send_chk("rp_z", 1'b0, 1'b0);
        send_chk("rp_1", 1'b1, 1'b0);
        send_chk("rp_2", 1'b1, 1'b0);
        send_chk("rp_3", 1'b0, 1'b0);
        send_chk("rp_4", 1'b1, 1'b1);

        // pat_load beats i_valid: the bit presented with the load is dropped
        pat_in   = 4'b1101;
        pat_load = 1'b1;
        i        = 1'b1;
        i_valid  = 1'b1;
        @(posedge tb_clk);
        @(negedge tb_clk);
        pat_load = 1'b0;
        i_valid  = 1'b0;
        chk_o("load_prio_o", 1'b0);
        send_chk("lp_b1", 1'b1, 1'b0);
        send_chk("lp_b2", 1'b0, 1'b0);
        send_chk("lp_b3", 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
